// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory write port of
// the program loader, plus its control/status lines.
//   master : loader side (takes start_load/rx_*, drives rx_ready, mem_*,
//            busy, run, load_err)
//   slave  : host/memory/fetch side (opposite directions)
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start_load;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              run;
  logic              load_err;

  modport master (
    input  start_load, rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, busy, run, load_err
  );

  modport slave (
    output start_load, rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, busy, run, load_err
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a little-endian image (LEN_LO, LEN_HI, then N
// words as low/high byte pairs) and writes it into instruction memory, then
// pulses run to start the fetch unit.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - program_loader_if.master (start_load, rx_valid/rx_data/rx_ready,
//           mem_we/mem_addr/mem_wdata, busy, run, load_err)
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over the data bytes before run is issued.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic               clk,
  input logic               reset,
  program_loader_if.master  bus
);

  localparam int          CW      = ADDR_W + 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        lo_q, lo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              pend_q, pend_d;  // DONE entered this cycle; run follows
  logic              run_q, run_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        ready;
  logic        accept;
  logic [15:0] len_full;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK: ready = 1'b1;
`endif
      default: ready = 1'b0;
    endcase
  end

  assign accept = bus.rx_valid && ready;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    run_d    = pend_q;
    len_full = {bus.rx_data, len_q[7:0]};
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE, S_ERR, S_DONE: begin
        // The first DONE cycle (pend_q) still ignores start_load.
        if (bus.start_load && !(state_q == S_DONE && pend_q)) begin
          state_d = S_LEN_LO;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: if (accept) begin
        len_d[7:0] = bus.rx_data;
        state_d    = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        len_d = len_full;
        if (len_full > DEPTH16)
          state_d = S_ERR;
        else if (len_full == '0)
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        else
          state_d = S_DATA_LO;
      end
      S_DATA_LO: if (accept) begin
        lo_d    = bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ bus.rx_data;
`endif
        state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept) begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_W-1:0];
        wdata_d = {bus.rx_data, lo_q};
        cnt_d   = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ bus.rx_data;
`endif
        if (16'(cnt_q) + 16'd1 == len_q)
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        else
          state_d = S_DATA_LO;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (accept) begin
        state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    pend_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = ready;
  assign bus.busy      = ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.run       = run_q;
  assign bus.load_err  = (state_q == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_run;
    logic [7:0]  addr;
    logic [15:0] data;
    int          gap;   // cycles since previous event, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   last_evt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [15:0] d, input int gap);
    exp_t e;
    e.is_run = 1'b0; e.addr = a; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic exp_run(input int gap);
    exp_t e;
    e.is_run = 1'b1; e.addr = '0; e.data = '0; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic handle(input bit is_run, input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      check(is_run ? "unexpected_run" : "unexpected_write", 32'(is_run), 32'(!is_run));
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(is_run), 32'(e.is_run));
      if (!is_run && !e.is_run) begin
        check("write_addr", 32'(a), 32'(e.addr));
        check("write_data", 32'(d), 32'(e.data));
      end
      if (e.gap >= 0) check("event_gap", 32'(cyc - last_evt), 32'(e.gap));
    end
    last_evt = cyc;
  endtask

  // Monitor: compares every write/run the DUT presents against the queue.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.mem_we) handle(1'b0, bus.mem_addr, bus.mem_wdata);
      if (bus.run)    handle(1'b1, '0, '0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  acc;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    do begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("rx_accept_timeout", 32'(acc), 32'd1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle_cycle(input bit sl);
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'hEE;
    bus.start_load = sl;
    @(posedge clk);
    #1;
    bus.start_load = 1'b0;
  endtask

  task automatic do_start();
    bus.start_load = 1'b1;
    @(posedge clk);
    #1;
    bus.start_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("expected_events_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [7:0] img3 [6];

  initial begin
    bus.start_load = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("reset_mem_we",   32'(bus.mem_we),   32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_wdata",    32'(bus.mem_wdata), 32'd0);
    check("reset_busy",     32'(bus.busy),     32'd0);
    check("reset_run",      32'(bus.run),      32'd0);
    check("reset_load_err", 32'(bus.load_err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // N=2 full-rate load: writes 2 cycles apart, run 1 cycle after last write
    exp_write(8'd0, 16'h1234, -1);
    exp_write(8'd1, 16'hABCD, 2);
    exp_run(1);
    do_start();
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("rx_ready_after_start", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hCD); send_byte(8'hAB);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h34 ^ 8'h12 ^ 8'hCD ^ 8'hAB);
`endif
    check("busy_after_last", 32'(bus.busy), 32'd0);
    drain();
    check("busy_done", 32'(bus.busy), 32'd0);

    // N=0: no writes, one run
    exp_run(-1);
    do_start();
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    drain();
    check("n0_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("n0_load_err", 32'(bus.load_err), 32'd0);

    // N=DEPTH+1: error, no writes, no run
    do_start();
    send_byte(8'h01); send_byte(8'h01);
    check("ovf_load_err",  32'(bus.load_err), 32'd1);
    check("ovf_rx_ready",  32'(bus.rx_ready), 32'd0);
    check("ovf_busy",      32'(bus.busy),     32'd0);
    idle_cycle(1'b0); idle_cycle(1'b0); idle_cycle(1'b0);
    check("ovf_load_err_sticky", 32'(bus.load_err), 32'd1);
    do_start();
    check("restart_clears_err", 32'(bus.load_err), 32'd0);
    check("restart_busy",       32'(bus.busy),     32'd1);
    exp_run(-1);
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    drain();

    // N=3 with rx_valid toggling; a start_load mid-load must be ignored
    img3[0] = 8'h01; img3[1] = 8'h5A; img3[2] = 8'hB2;
    img3[3] = 8'hC3; img3[4] = 8'h00; img3[5] = 8'h7F;
    exp_write(8'd0, 16'h5A01, -1);
    exp_write(8'd1, 16'hC3B2, 4);
    exp_write(8'd2, 16'h7F00, 4);
    exp_run(1);
    do_start();
    idle_cycle(1'b0); send_byte(8'h03);
    idle_cycle(1'b0); send_byte(8'h00);
    for (int i = 0; i < 6; i++) begin
      idle_cycle(i == 2);
      send_byte(img3[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    idle_cycle(1'b0);
    send_byte(8'h01 ^ 8'h5A ^ 8'hB2 ^ 8'hC3 ^ 8'h00 ^ 8'h7F);
`endif
    drain();

    // Asynchronous reset after the 3rd data byte
    exp_write(8'd0, 16'h2211, -1);
    do_start();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("arst_mem_we",   32'(bus.mem_we),   32'd0);
    check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_wdata",    32'(bus.mem_wdata), 32'd0);
    check("arst_busy",     32'(bus.busy),     32'd0);
    check("arst_run",      32'(bus.run),      32'd0);
    check("arst_load_err", 32'(bus.load_err), 32'd0);
    check("arst_events_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_write(8'd0, 16'hBEEF, -1);
    exp_write(8'd1, 16'h0102, 2);
    exp_run(1);
    do_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE);
    send_byte(8'h02); send_byte(8'h01);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hEF ^ 8'hBE ^ 8'h02 ^ 8'h01);
`endif
    drain();

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch on N=1, word 0x00FF
    exp_write(8'd0, 16'h00FF, -1);
    exp_run(2);
    do_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'hFF);
    drain();
    check("chk_ok_err", 32'(bus.load_err), 32'd0);
    exp_write(8'd0, 16'h00FF, -1);
    do_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
    drain();
    check("chk_bad_err", 32'(bus.load_err), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image from a byte-wide source (UART receiver or test host) into the instruction memory consumed by the fetch unit, then pulses `run` to start execution. It sits upstream of the instruction fetch unit and the core. It owns the memory write port while loading and releases it when finished. It parses a length header, packs byte pairs into 16-bit instruction words and checks the image size against memory depth.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction memory address width.
- `DEPTH`, default 256: number of 16-bit words in memory; must be ≤ 2^ADDR_W.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start_load`, input, 1: one-cycle request to begin a load; ignored unless in IDLE, DONE or ERR.
- `rx_valid`, input, 1: a byte is offered on `rx_data`.
- `rx_data`, input, 8: the offered byte.
- `rx_ready`, output, 1: loader accepts a byte this cycle. A byte is consumed when `rx_valid && rx_ready`.
- `mem_we`, output, 1: instruction memory write strobe, one cycle per word.
- `mem_addr`, output, ADDR_W: write address.
- `mem_wdata`, output, 16: write data.
- `busy`, output, 1: high from load start until DONE or ERR.
- `run`, output, 1: one-cycle pulse to the fetch unit after a successful load.
- `load_err`, output, 1: sticky error flag, cleared on the next `start_load`.

## Operation
- Image format, little-endian: `LEN_LO`, `LEN_HI` (word count N), then N words, each sent as low byte then high byte.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK (present only with the macro), DONE, ERR.
- IDLE/DONE/ERR + `start_load` → LEN_LO. This clears `load_err`, the word counter and the checksum, and sets `busy`.
- LEN_LO: on accept, latch N[7:0] → LEN_HI.
- LEN_HI: on accept, latch N[15:8], then:
  - if N > DEPTH → ERR;
  - else if N == 0 → CHK (macro) or DONE;
  - else → DATA_LO.
- DATA_LO: on accept, hold the byte → DATA_HI.
- DATA_HI: on accept, write {byte, held_lo} to address = word counter, then increment the counter.
  - If counter+1 == N → CHK (macro) or DONE.
  - Otherwise → DATA_LO.
- CHK: described under Configuration.
- ERR: `load_err`=1, `busy`=0, no `run`, no further writes.
- Entering DONE pulses `run` for one cycle and drops `busy`.
- `rx_ready` = 1 exactly in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK; it is combinational from state only, never from `rx_valid`.
- Arithmetic:
  - The word counter is ADDR_W+1 bits, so N = DEPTH = 2^ADDR_W is representable.
  - `mem_addr` is the low ADDR_W bits of the counter.
  - The N comparison is done on 16 bits.
- Simultaneous `start_load` while busy: ignored.
- `start_load` in the same cycle as DONE entry: ignored. Restart is accepted from the next cycle.
- Reset mid-load: immediately returns to IDLE with all outputs at reset values. The memory contents written so far are left as is.

## Timing
- Reset values: `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `run`=0, `load_err`=0, state IDLE.
- `busy` rises the cycle after `start_load` is sampled.
- `mem_we`/`mem_addr`/`mem_wdata` are registered: asserted for exactly one cycle, on the cycle after the high byte is accepted.
- Without the macro, `run` is asserted in the cycle after the final `mem_we` cycle, so the memory holds the last word before fetch begins.
- With N == 0, `run` pulses 1 cycle after LEN_HI accept (no macro) or 1 cycle after CHK accept (macro).
- Throughput: one byte per cycle when `rx_valid` is held high, which gives one word per 2 cycles. Back-to-back writes on consecutive `mem_we` pulses are 2 cycles apart.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A trailing checksum byte follows the data.
  - Checksum = XOR of every byte after `LEN_HI`, i.e. the data bytes only.
  - In CHK, on accept: match → DONE (`run` pulse); mismatch → ERR.
  - The words are already written when a mismatch is found; `run` is withheld.
- `LOADER_CHECKSUM_EN` undefined:
  - No CHK state and no checksum logic.
  - The last DATA_HI accept goes straight to DONE.

## Test plan
- Load N=2, words 0x1234, 0xABCD, byte stream 02 00 34 12 CD AB → `mem_we` at addr 0 data 0x1234, then at addr 1 data 0xABCD 2 cycles later. `run` pulses 1 cycle after that and `busy` falls.
- N=0 (bytes 00 00) → no `mem_we`, one `run` pulse; with the macro, checksum byte 00 is required first.
- N=DEPTH+1 (ADDR_W=8: 01 01) → ERR after `LEN_HI`, `load_err`=1, `rx_ready`=0, no writes, no `run`; a later `start_load` clears `load_err`.
- `rx_valid` toggled every other cycle during a 3-word load → all 3 writes correct at addrs 0..2, and no byte is consumed while `rx_valid`=0.
- Reset asserted asynchronously after the 3rd data byte → all outputs 0 within the same cycle, state IDLE; a new full load then succeeds from addr 0.
- Macro on: N=1, 0x00FF, checksum FF → `run`; same image with checksum 00 → `load_err`=1, no `run`, and the word is still written.
